// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes (also used by decode), default widths and the
// multiply FSM state encoding.
package alu_pkg;

    localparam int ALU_WIDTH   = 10;
    localparam int ALU_SHAMT_W = 4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } mul_state_t;

endpackage

// File: rtl/seq_mult10.sv
// Iterative shift-add multiplier: one partial product per clock, fixed WIDTH-cycle
// latency. 'product' is valid combinationally in the cycle 'done' is high.
module seq_mult10
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mul_state_t       state_reg, state_next;
    logic [WIDTH-1:0] mcand_reg, mplr_reg, acc_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_sum;

    // Only the low WIDTH bits of the product are kept, so the multiplicand
    // may simply shift out of range.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_partial
            assign partial[gi] = mcand_reg[gi] & mplr_reg[0];
        end
    endgenerate

    assign acc_sum = acc_reg + partial;
    assign product = acc_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (start) state_next = ST_MUL_BUSY;
            ST_MUL_BUSY: if (count_reg == LAST) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == ST_MUL_BUSY);
        done = (state_reg == ST_MUL_BUSY) && (count_reg == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_reg <= '0;
            mplr_reg  <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            if (start) begin
                mcand_reg <= a;
                mplr_reg  <= b;
                acc_reg   <= '0;
                count_reg <= '0;
            end
        end else begin
            acc_reg   <= acc_sum;
            mcand_reg <= mcand_reg << 1;
            mplr_reg  <= mplr_reg >> 1;
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ex_stage_alu.sv
// Execute stage: combinational ALU plus output registers. Define EX_STAGE_MUL_EN to
// get the multi-cycle MUL with upstream stall; otherwise MUL returns 0 in one cycle.
module ex_stage_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] aluA_in,
    input  logic [WIDTH-1:0] aluB_in,
    input  logic [2:0]       alu_ctrl_in,
    input  logic             gp_reg_wb_in,
    input  logic [2:0]       gp_wb_address_in,
    output logic [WIDTH-1:0] result_out,
    output logic             zero_out,
    output logic             gp_reg_wb_out,
    output logic [2:0]       gp_wb_address_out,
    output logic             stall_out
);

    logic [WIDTH-1:0]   alu_res;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = aluB_in[SHAMT_W-1:0];

    // Shifting a WIDTH-bit value by >= WIDTH already yields zero, which covers
    // the out-of-range shift amounts without an explicit compare.
    always_comb begin
        alu_res = '0;
        case (alu_ctrl_in)
            ALU_ADD: alu_res = aluA_in + aluB_in;
            ALU_SUB: alu_res = aluA_in - aluB_in;
            ALU_AND: alu_res = aluA_in & aluB_in;
            ALU_OR:  alu_res = aluA_in | aluB_in;
            ALU_XOR: alu_res = aluA_in ^ aluB_in;
            ALU_SLL: alu_res = aluA_in << shamt;
            ALU_SRL: alu_res = aluA_in >> shamt;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_STAGE_MUL_EN
    logic             mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             pend_wb_reg;
    logic [2:0]       pend_addr_reg;

    assign mul_start = ~mul_busy && (alu_ctrl_in == ALU_MUL);
    assign stall_out = mul_busy;

    seq_mult10 #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst     (reset),
        .start   (mul_start),
        .a       (aluA_in),
        .b       (aluB_in),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_out        <= '0;
            zero_out          <= 1'b0;
            gp_reg_wb_out     <= 1'b0;
            gp_wb_address_out <= '0;
            pend_wb_reg       <= 1'b0;
            pend_addr_reg     <= '0;
        end else if (mul_done) begin
            result_out        <= mul_product;
            zero_out          <= (mul_product == '0);
            gp_reg_wb_out     <= pend_wb_reg;
            gp_wb_address_out <= pend_addr_reg;
        end else if (mul_busy) begin
            gp_reg_wb_out <= 1'b0;
        end else if (mul_start) begin
            // Bubble downstream; result/zero keep the previous instruction's values.
            pend_wb_reg   <= gp_reg_wb_in;
            pend_addr_reg <= gp_wb_address_in;
            gp_reg_wb_out <= 1'b0;
        end else begin
            result_out        <= alu_res;
            zero_out          <= (alu_res == '0);
            gp_reg_wb_out     <= gp_reg_wb_in;
            gp_wb_address_out <= gp_wb_address_in;
        end
    end
`else
    assign stall_out = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_out        <= '0;
            zero_out          <= 1'b0;
            gp_reg_wb_out     <= 1'b0;
            gp_wb_address_out <= '0;
        end else begin
            result_out        <= alu_res;
            zero_out          <= (alu_res == '0);
            gp_reg_wb_out     <= gp_reg_wb_in;
            gp_wb_address_out <= gp_wb_address_in;
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage_alu.sv
// Directed bench for ex_stage_alu; MUL sequences follow the EX_STAGE_MUL_EN build setting.
module tb_ex_stage_alu;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] aluA_in = '0;
    logic [9:0] aluB_in = '0;
    logic [2:0] alu_ctrl_in = '0;
    logic       gp_reg_wb_in = 1'b0;
    logic [2:0] gp_wb_address_in = '0;
    logic [9:0] result_out;
    logic       zero_out;
    logic       gp_reg_wb_out;
    logic [2:0] gp_wb_address_out;
    logic       stall_out;

    int total = 0;
    int bad   = 0;

    ex_stage_alu dut (
        .clk               (clk),
        .reset             (reset),
        .aluA_in           (aluA_in),
        .aluB_in           (aluB_in),
        .alu_ctrl_in       (alu_ctrl_in),
        .gp_reg_wb_in      (gp_reg_wb_in),
        .gp_wb_address_in  (gp_wb_address_in),
        .result_out        (result_out),
        .zero_out          (zero_out),
        .gp_reg_wb_out     (gp_reg_wb_out),
        .gp_wb_address_out (gp_wb_address_out),
        .stall_out         (stall_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock edge; outputs are then sampled on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] op, input logic [9:0] a, input logic [9:0] b,
                         input logic wb, input logic [2:0] addr);
        alu_ctrl_in      = op;
        aluA_in          = a;
        aluB_in          = b;
        gp_reg_wb_in     = wb;
        gp_wb_address_in = addr;
    endtask

    task automatic op_check(input string tag, input logic [2:0] op, input logic [9:0] a,
                            input logic [9:0] b, input logic wb, input logic [2:0] addr,
                            input logic [9:0] exp_res);
        drive(op, a, b, wb, addr);
        tick();
        check({tag, "_res"}, 16'(result_out), 16'(exp_res));
        check({tag, "_zero"}, 16'(zero_out), 16'(exp_res == 10'd0));
        check({tag, "_wb"}, 16'(gp_reg_wb_out), 16'(wb));
        check({tag, "_addr"}, 16'(gp_wb_address_out), 16'(addr));
        check({tag, "_stall"}, 16'(stall_out), 16'd0);
        $display("op=%0d a=%0h b=%0h -> result=%0h zero=%0b wb=%0b addr=%0d",
                 op, a, b, result_out, zero_out, gp_reg_wb_out, gp_wb_address_out);
    endtask

    initial begin
        @(negedge clk);
        tick();
        check("rst_res", 16'(result_out), 16'd0);
        check("rst_zero", 16'(zero_out), 16'd0);
        check("rst_wb", 16'(gp_reg_wb_out), 16'd0);
        check("rst_addr", 16'(gp_wb_address_out), 16'd0);
        check("rst_stall", 16'(stall_out), 16'd0);
        reset = 1'b0;

        op_check("add_wrap", 3'b000, 10'h3FF, 10'h001, 1'b1, 3'd5, 10'h000);
        op_check("sub_neg",  3'b001, 10'd5,   10'd7,   1'b0, 3'd2, 10'h3FE);
        op_check("and",      3'b010, 10'h3F0, 10'h0FF, 1'b1, 3'd1, 10'h0F0);
        op_check("or",       3'b011, 10'h300, 10'h005, 1'b1, 3'd6, 10'h305);
        op_check("xor",      3'b100, 10'h3FF, 10'h155, 1'b1, 3'd7, 10'h2AA);
        op_check("sll9",     3'b101, 10'h001, 10'd9,   1'b1, 3'd3, 10'h200);
        op_check("sll10",    3'b101, 10'h001, 10'd10,  1'b1, 3'd3, 10'h000);
        op_check("srl12",    3'b110, 10'h3FF, 10'd12,  1'b1, 3'd4, 10'h000);
        op_check("srl_hib",  3'b110, 10'h200, 10'h013, 1'b1, 3'd4, 10'h040);

`ifdef EX_STAGE_MUL_EN
        // MUL 25*30 with the next ADD held upstream for the whole stall.
        drive(3'b111, 10'd25, 10'd30, 1'b1, 3'd3);
        tick();
        drive(3'b000, 10'd1, 10'd2, 1'b1, 3'd6);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("mul1_stall%0d", i), 16'(stall_out), 16'd1);
            check($sformatf("mul1_wb%0d", i), 16'(gp_reg_wb_out), 16'd0);
            check($sformatf("mul1_hold%0d", i), 16'(result_out), 16'h040);
            tick();
        end
        check("mul1_stall_end", 16'(stall_out), 16'd0);
        check("mul1_res", 16'(result_out), 16'h2EE);
        check("mul1_zero", 16'(zero_out), 16'd0);
        check("mul1_wb", 16'(gp_reg_wb_out), 16'd1);
        check("mul1_addr", 16'(gp_wb_address_out), 16'd3);
        $display("mul 25*30 -> result=%0h wb=%0b addr=%0d", result_out, gp_reg_wb_out, gp_wb_address_out);
        tick();
        check("held_add_res", 16'(result_out), 16'd3);
        check("held_add_addr", 16'(gp_wb_address_out), 16'd6);
        $display("held add 1+2 -> result=%0h", result_out);

        // Full-scale MUL followed immediately by a second MUL.
        drive(3'b111, 10'h3FF, 10'h3FF, 1'b1, 3'd2);
        tick();
        drive(3'b111, 10'd2, 10'd3, 1'b1, 3'd5);
        for (int i = 0; i < 10; i++) tick();
        check("mul2_res", 16'(result_out), 16'h001);
        check("mul2_addr", 16'(gp_wb_address_out), 16'd2);
        check("mul2_stall_gap", 16'(stall_out), 16'd0);
        $display("mul 3ff*3ff -> result=%0h", result_out);
        tick();
        check("mul3_stall", 16'(stall_out), 16'd1);
        drive(3'b000, 10'd0, 10'd0, 1'b0, 3'd0);
        for (int i = 0; i < 9; i++) tick();
        check("mul3_stall_last", 16'(stall_out), 16'd1);
        tick();
        check("mul3_res", 16'(result_out), 16'd6);
        check("mul3_wb", 16'(gp_reg_wb_out), 16'd1);
        check("mul3_addr", 16'(gp_wb_address_out), 16'd5);
        $display("mul 2*3 -> result=%0h addr=%0d", result_out, gp_wb_address_out);

        // Reset during busy cycle 4 abandons the multiply.
        drive(3'b111, 10'd7, 10'd9, 1'b1, 3'd4);
        tick();
        for (int i = 0; i < 3; i++) tick();
        check("rmul_busy", 16'(stall_out), 16'd1);
        reset = 1'b1;
        #1;
        check("rmul_stall", 16'(stall_out), 16'd0);
        check("rmul_res", 16'(result_out), 16'd0);
        check("rmul_wb", 16'(gp_reg_wb_out), 16'd0);
        check("rmul_addr", 16'(gp_wb_address_out), 16'd0);
        $display("reset mid-mul -> stall=%0b result=%0h", stall_out, result_out);
        @(negedge clk);
        reset = 1'b0;
        drive(3'b000, 10'd0, 10'd0, 1'b0, 3'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("rmul_nowb%0d", i), 16'(gp_reg_wb_out), 16'd0);
        end
        op_check("post_rst_add", 3'b000, 10'd4, 10'd5, 1'b1, 3'd1, 10'd9);
`else
        op_check("mul_off", 3'b111, 10'd4, 10'd4, 1'b1, 3'd7, 10'h000);
        op_check("after_mul_off", 3'b000, 10'd4, 10'd5, 1'b1, 3'd1, 10'd9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
